// File: rtl/mercury2_dac_rx.sv
// -----------------------------------------------------------------------------
// mercury2_dac_rx
// Receiver for the Mercury2 dual 10-bit DAC serial stream. The serial lines are
// oversampled by clk_50MHZ. Each frame is decoded into the input register of
// channel A or B. The input registers are copied to the outputs whenever the
// synchronised LDAC is low.
//
// Ports
//   clk_50MHZ   in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   dac_csn     in   chip select, active low (asynchronous)
//   dac_sck     in   serial clock, data taken on its rising edge (asynchronous)
//   dac_sdi     in   serial data, MSB first (asynchronous)
//   dac_ldac    in   latch, active low, level sensitive (asynchronous)
//   dac0_value  out  channel A output register
//   dac1_value  out  channel B output register
//   dac_gain2x  out  per-channel 2x gain flag (GA bit was 0)
//   dac_on      out  per-channel active flag (SHDN bit was 1)
//   frame_done  out  one-clock pulse, valid frame written to an input register
//   frame_err   out  one-clock pulse, frame ended with a bad bit count
// -----------------------------------------------------------------------------
module mercury2_dac_rx #(
  parameter int FRAME_BITS = 16
) (
  input  logic       clk_50MHZ,
  input  logic       reset_n,
  input  logic       dac_csn,
  input  logic       dac_sck,
  input  logic       dac_sdi,
  input  logic       dac_ldac,
  output logic [9:0] dac0_value,
  output logic [9:0] dac1_value,
  output logic [1:0] dac_gain2x,
  output logic [1:0] dac_on,
  output logic       frame_done,
  output logic       frame_err
);

  localparam logic [5:0] FRAME_CNT = 6'(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Synchroniser stage (two flops per line, third flop for edge detection)
  logic csn_m, csn_s, csn_d;
  logic sck_m, sck_s, sck_d;
  logic sdi_m, sdi_s;
  logic ldac_m, ldac_s;

  always_ff @(posedge clk_50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      csn_m  <= 1'b1;
      csn_s  <= 1'b1;
      csn_d  <= 1'b1;
      sck_m  <= 1'b0;
      sck_s  <= 1'b0;
      sck_d  <= 1'b0;
      sdi_m  <= 1'b0;
      sdi_s  <= 1'b0;
      ldac_m <= 1'b1;
      ldac_s <= 1'b1;
    end else begin
      csn_m  <= dac_csn;
      csn_s  <= csn_m;
      csn_d  <= csn_s;
      sck_m  <= dac_sck;
      sck_s  <= sck_m;
      sck_d  <= sck_s;
      sdi_m  <= dac_sdi;
      sdi_s  <= sdi_m;
      ldac_m <= dac_ldac;
      ldac_s <= ldac_m;
    end
  end

  logic csn_fall, csn_rise, sck_rise;
  assign csn_fall = csn_d & ~csn_s;
  assign csn_rise = ~csn_d & csn_s;
  assign sck_rise = ~sck_d & sck_s;

  // Frame decoder stage
  state_t      state, state_nxt;
  logic [15:0] shift, shift_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic        commit_ok, commit_bad;

  always_ff @(posedge clk_50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      shift <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shift <= shift_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The commit decision is taken on the SHIFT->COMMIT transition using the
  // already-updated count/shift value. A bit clocked in on the same cycle as
  // the CS rise is therefore counted, and the register write and pulse land
  // with the COMMIT cycle itself.
  always_comb begin
    state_nxt  = state;
    shift_nxt  = shift;
    cnt_nxt    = cnt;
    commit_ok  = 1'b0;
    commit_bad = 1'b0;
    case (state)
      IDLE: begin
        if (csn_fall) begin
          shift_nxt = '0;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (sck_rise) begin
          shift_nxt = {shift[14:0], sdi_s};
          if (cnt != 5'd31) cnt_nxt = cnt + 5'd1;
        end
        if (csn_rise) begin
          state_nxt = COMMIT;
          if ({1'b0, cnt_nxt} == FRAME_CNT) commit_ok = 1'b1;
          else commit_bad = 1'b1;
        end
      end
      COMMIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Input register stage
  logic [9:0] in0_value, in1_value;
  logic [1:0] in_gain2x, in_on;

  always_ff @(posedge clk_50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      in0_value  <= '0;
      in1_value  <= '0;
      in_gain2x  <= '0;
      in_on      <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= commit_ok;
      frame_err  <= commit_bad;
      if (commit_ok) begin
        if (shift_nxt[15]) begin
          in1_value    <= shift_nxt[11:2];
          in_gain2x[1] <= ~shift_nxt[13];
          in_on[1]     <= shift_nxt[12];
        end else begin
          in0_value    <= shift_nxt[11:2];
          in_gain2x[0] <= ~shift_nxt[13];
          in_on[0]     <= shift_nxt[12];
        end
      end
    end
  end

  // Output register stage (transparent while LDAC is low)
  always_ff @(posedge clk_50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      dac0_value <= '0;
      dac1_value <= '0;
      dac_gain2x <= '0;
      dac_on     <= '0;
    end else if (!ldac_s) begin
      dac0_value <= in0_value;
      dac1_value <= in1_value;
      dac_gain2x <= in_gain2x;
      dac_on     <= in_on;
    end
  end

endmodule
